rca_wrap: RTL and testbench

- Registered N-bit ripple-carry adder: a chain of N one-bit full adders, with the result captured into output registers.
- Sits behind the rca interface's DUT-side port. The interface carries stimulus in and results out, and the testers check every result against a+b+cin.
- Single clock domain, asynchronous active-low reset.

---
 rtl/rca_pkg.sv | 11 +
 rtl/rca_full_adder.sv | 16 +
 rtl/rca_wrap.sv | 52 +++++
 tb/tb_rca_wrap.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared width constant and result record for the registered ripple-carry adder.
package rca_pkg;

  localparam int RCA_N = 4;

  typedef struct packed {
    logic             cout;
    logic [RCA_N-1:0] sum;
  } rca_result_t;

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder cell used as a stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_wrap.sv
// N-bit ripple-carry adder built from full_adder cells, with the sum, carry-out,
// signed overflow and a valid flag captured into output registers.
module rca_wrap
  import rca_pkg::*;
#(
  parameter int N = RCA_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         in_valid,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid
);

  logic [N:0]   c;
  logic [N-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Result registers only load on in_valid, so idle-cycle operands never reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[N];
        ovf  <= c[N-1] ^ c[N];
      end
    end
  end

endmodule

// File: tb/tb_rca_wrap.sv
// Self-checking bench for rca_wrap: directed table, exhaustive sweep, random traffic and reset cases.
module tb_rca_wrap;
  import rca_pkg::*;

  localparam int N = RCA_N;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last accepted result.
  logic [N-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;
  logic         m_valid;

  rca_wrap #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         v;
    logic [N-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [N-1:0] va, input logic [N-1:0] vb,
                                  input logic vc, input logic vv, input logic [N-1:0] es,
                                  input logic ec, input logic eo, input logic ev);
    vec_t t;
    t.a = va; t.b = vb; t.cin = vc; t.v = vv;
    t.e_sum = es; t.e_cout = ec; t.e_ovf = eo; t.e_valid = ev;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [N-1:0] es, input logic ec,
                         input logic eo, input logic ev);
    chk({name, ".sum"}, int'(sum), int'(es));
    chk({name, ".cout"}, int'(cout), int'(ec));
    chk({name, ".ovf"}, int'(ovf), int'(eo));
    chk({name, ".out_valid"}, int'(out_valid), int'(ev));
  endtask

  // Reference: plain unsigned and signed integer arithmetic on the operands.
  task automatic model_step(input logic [N-1:0] va, input logic [N-1:0] vb,
                            input logic vc, input logic vv);
    int u, sa, sb, st;
    m_valid = vv;
    if (vv) begin
      u  = int'(va) + int'(vb) + int'(vc);
      sa = va[N-1] ? int'(va) - (1 << N) : int'(va);
      sb = vb[N-1] ? int'(vb) - (1 << N) : int'(vb);
      st = sa + sb + int'(vc);
      m_sum  = N'(u);
      m_cout = u[N];
      m_ovf  = (st > (1 << (N-1)) - 1) || (st < -(1 << (N-1)));
    end
  endtask

  task automatic step(input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic vc, input logic vv);
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = vv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;

    add_vec(4'h3, 4'h4, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    add_vec(4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    add_vec(4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
    add_vec(4'h7, 4'h1, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1);
    add_vec(4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
    add_vec(4'h2, 4'h3, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    add_vec(4'h9, 4'h9, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    add_vec(4'h9, 4'h9, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    add_vec(4'h1, 4'h1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    add_vec(4'h6, 4'h2, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1);

    #12;
    chk_all("reset_init", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset between edges with a live all-ones result.
    step(4'hF, 4'h0, 1'b0, 1'b1);
    chk_all("pre_reset", 4'hF, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_release_idle", 4'h0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].v);
      chk_all($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_cout,
              vecs[i].e_ovf, vecs[i].e_valid);
    end
    model_step(4'h6, 4'h2, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep.
    for (int ci = 0; ci < 2; ci++) begin
      for (int ia = 0; ia < (1 << N); ia++) begin
        for (int ib = 0; ib < (1 << N); ib++) begin
          step(N'(ia), N'(ib), ci[0], 1'b1);
          model_step(N'(ia), N'(ib), ci[0], 1'b1);
          chk_all($sformatf("exh_%0d_%0d_%0d", ia, ib, ci), m_sum, m_cout, m_ovf, m_valid);
        end
      end
    end

    // Random traffic with idle cycles carrying arbitrary operands.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] ra, rb;
      logic         rc, rv;
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      step(ra, rb, rc, rv);
      model_step(ra, rb, rc, rv);
      chk_all($sformatf("rand%0d", k), m_sum, m_cout, m_ovf, m_valid);
    end

    // Reset asserted while an operand is in flight: that result must be discarded.
    @(negedge clk);
    a = 4'h5; b = 4'h5; cin = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all("midreset_held", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("midreset_idle", 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'hA, 4'h3, 1'b1, 1'b1);
    chk_all("midreset_first", 4'hE, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
